sprite_move_ctrl: RTL and testbench

SPRITE_MOVE_CTRL -- requirements
Module: sprite_move_ctrl

---
 rtl/pong_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 49 ++++
 rtl/sprite_move_ctrl.sv | 112 +++++++++++
 tb/tb_sprite_move_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants and encodings for the pong sprite datapath.
package pong_pkg;

  localparam int unsigned H_LAST      = 639;
  localparam int unsigned V_LAST      = 479;
  localparam int unsigned SQUARE_SIZE = 25;
  localparam int unsigned COORD_W     = 10;
  localparam int unsigned MODE_W      = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_IDLE   = 2'b00,
    MODE_MANUAL = 2'b01,
    MODE_AUTO   = 2'b10
  } mode_e;

  typedef struct packed {
    logic r;
    logic l;
  } turn_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer for one raw button.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_i,
  output logic deb_o
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synced level disagrees with the accepted one;
  // any cycle of agreement restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/sprite_move_ctrl.sv
// Sprite movement controller: frame tick, button/autopilot mode FSM and
// frame-synchronous left/right move requests.
module sprite_move_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned AUTO_MIN_X = 0,
  parameter int unsigned AUTO_MAX_X = 615
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               btn_r,
  input  logic               btn_l,
  input  logic               auto_en,
  input  logic [COORD_W-1:0] sq_x,
  output logic               refr_tick,
  output logic               turn_r,
  output logic               turn_l,
  output logic [MODE_W-1:0]  mode
);

  logic  deb_r, deb_l;
  logic  man_req_c, at_last_c;
  logic  at_last_q, tick_q;
  logic  dir_q, dir_d;
  mode_e state_q, state_d;
  turn_t turn_q, turn_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
    .clk   (clk),
    .rstn  (rstn),
    .btn_i (btn_r),
    .deb_o (deb_r)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
    .clk   (clk),
    .rstn  (rstn),
    .btn_i (btn_l),
    .deb_o (deb_l)
  );

  assign at_last_c = (pixel_x == COORD_W'(H_LAST)) && (pixel_y == COORD_W'(V_LAST));
  assign man_req_c = deb_r ^ deb_l;

  // Mode transitions, autopilot bounce direction and per-frame turn requests.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    turn_d  = turn_q;

    case (state_q)
      MODE_IDLE: begin
        if (man_req_c)    state_d = MODE_MANUAL;
        else if (auto_en) state_d = MODE_AUTO;
      end
      MODE_MANUAL: begin
        if (!man_req_c)   state_d = MODE_IDLE;
      end
      MODE_AUTO: begin
        if (man_req_c)     state_d = MODE_MANUAL;
        else if (!auto_en) state_d = MODE_IDLE;
      end
      default: state_d = MODE_IDLE;
    endcase

    if (tick_q && (state_q == MODE_AUTO)) begin
      if (sq_x >= COORD_W'(AUTO_MAX_X))      dir_d = 1'b0;
      else if (sq_x <= COORD_W'(AUTO_MIN_X)) dir_d = 1'b1;
    end

    // Masking keeps the pair exclusive even if both buttons settle mid-frame.
    if (tick_q) begin
      turn_d = '0;
      case (state_q)
        MODE_MANUAL: begin
          turn_d.r = deb_r & ~deb_l;
          turn_d.l = deb_l & ~deb_r;
        end
        MODE_AUTO: begin
          turn_d.r = dir_d;
          turn_d.l = ~dir_d;
        end
        default: turn_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= MODE_IDLE;
      at_last_q <= 1'b0;
      tick_q    <= 1'b0;
      dir_q     <= 1'b1;
      turn_q    <= '0;
    end else begin
      state_q   <= state_d;
      at_last_q <= at_last_c;
      tick_q    <= at_last_c & ~at_last_q;
      dir_q     <= dir_d;
      turn_q    <= turn_d;
    end
  end

  assign refr_tick = tick_q;
  assign turn_r    = turn_q.r;
  assign turn_l    = turn_q.l;
  assign mode      = state_q;

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// Directed and randomized bench for sprite_move_ctrl against a cycle-level reference model.
module tb_sprite_move_ctrl;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [9:0] pixel_x, pixel_y, sq_x;
  logic       btn_r, btn_l, auto_en;
  logic       refr_tick, turn_r, turn_l;
  logic [1:0] mode;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_cnt = 0;
  int tick_mark;

  // Drive values applied at the next falling edge.
  bit       d_br, d_bl, d_ae;
  bit [9:0] d_px, d_py, d_sq;

  // Reference model state; raw button samples kept newest at the back.
  bit m_hr[$];
  bit m_hl[$];
  bit m_deb_r, m_deb_l, m_prev_last, m_tick, m_dir, m_tr, m_tl;
  int m_mode;

  always #5 clk = ~clk;

  sprite_move_ctrl #(
    .DEB_CYCLES (DEB),
    .AUTO_MIN_X (0),
    .AUTO_MAX_X (615)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .btn_r     (btn_r),
    .btn_l     (btn_l),
    .auto_en   (auto_en),
    .sq_x      (sq_x),
    .refr_tick (refr_tick),
    .turn_r    (turn_r),
    .turn_l    (turn_l),
    .mode      (mode)
  );

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hr.delete();
    m_hl.delete();
    for (int i = 0; i < int'(DEB) + 2; i++) begin
      m_hr.push_back(1'b0);
      m_hl.push_back(1'b0);
    end
    m_deb_r = 0; m_deb_l = 0; m_prev_last = 0; m_tick = 0;
    m_dir = 1; m_tr = 0; m_tl = 0; m_mode = 0;
  endtask

  // Synced level lags raw by two edges; it is accepted once the last DEB synced
  // samples all differ from the current accepted level.
  function automatic bit flips(input bit h[$], input bit deb);
    flips = 1'b1;
    for (int k = 0; k < int'(DEB); k++)
      if (h[h.size() - 2 - k] == deb) flips = 1'b0;
  endfunction

  task automatic model_edge();
    bit lr, nt, req, nd, nr, nl;
    int nm;
    lr  = (pixel_x == 10'd639) && (pixel_y == 10'd479);
    nt  = lr && !m_prev_last;
    req = (m_deb_r != m_deb_l);
    if (req)                       nm = 1;
    else if (m_mode == 1)          nm = 0;
    else                           nm = auto_en ? 2 : 0;
    nd = m_dir;
    if (m_tick && m_mode == 2) begin
      if (sq_x >= 10'd615)      nd = 0;
      else if (sq_x == 10'd0)   nd = 1;
    end
    if (m_tick) begin
      m_tr = (m_mode == 1 && m_deb_r && !m_deb_l) || (m_mode == 2 && nd);
      m_tl = (m_mode == 1 && m_deb_l && !m_deb_r) || (m_mode == 2 && !nd);
    end
    nr = flips(m_hr, m_deb_r) ? !m_deb_r : m_deb_r;
    nl = flips(m_hl, m_deb_l) ? !m_deb_l : m_deb_l;
    m_hr.push_back(btn_r); void'(m_hr.pop_front());
    m_hl.push_back(btn_l); void'(m_hl.pop_front());
    m_deb_r = nr; m_deb_l = nl; m_prev_last = lr; m_tick = nt;
    m_dir = nd; m_mode = nm;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      btn_r = d_br; btn_l = d_bl; auto_en = d_ae;
      pixel_x = d_px; pixel_y = d_py; sq_x = d_sq;
      @(posedge clk);
      model_edge();
      #1;
      if (refr_tick === 1'b1) tick_cnt++;
      chk("refr_tick", 10'(refr_tick), 10'(m_tick));
      chk("turn_r",    10'(turn_r),    10'(m_tr));
      chk("turn_l",    10'(turn_l),    10'(m_tl));
      chk("mode",      10'(mode),      10'(m_mode));
    end
  endtask

  task automatic frame();
    d_px = 10'd639; d_py = 10'd479; cyc(1);
    d_px = 10'd0;   d_py = 10'd0;   cyc(3);
  endtask

  // Async reset between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    chk("rst_tick", 10'(refr_tick), 10'd0);
    chk("rst_tr",   10'(turn_r),    10'd0);
    chk("rst_tl",   10'(turn_l),    10'd0);
    chk("rst_mode", 10'(mode),      10'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    btn_r = 0; btn_l = 0; auto_en = 0;
    pixel_x = 0; pixel_y = 0; sq_x = 0;
    d_br = 0; d_bl = 0; d_ae = 0; d_px = 0; d_py = 0; d_sq = 10'd300;
    model_reset();
    #1;
    chk("init_tick", 10'(refr_tick), 10'd0);
    chk("init_mode", 10'(mode),      10'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Frame tick: one pulse per arrival, none while held.
    d_px = 10'd639; d_py = 10'd479; cyc(10);
    chk("tick_once", 10'(tick_cnt), 10'd1);
    d_px = 10'd0; d_py = 10'd0; cyc(3);
    chk("tick_hold", 10'(tick_cnt), 10'd1);
    d_px = 10'd639; d_py = 10'd479; cyc(2);
    chk("tick_twice", 10'(tick_cnt), 10'd2);
    d_px = 10'd0; d_py = 10'd0; cyc(2);

    // Glitchy right press, then stable.
    d_br = 1; cyc(1); d_br = 0; cyc(1); d_br = 1; cyc(1);
    chk("glitch_mode", 10'(mode), 10'd0);
    cyc(10);
    chk("man_mode", 10'(mode), 10'd1);
    frame();
    chk("man_tr", 10'(turn_r), 10'd1);
    chk("man_tl", 10'(turn_l), 10'd0);

    // Both held is no request.
    d_bl = 1; cyc(10);
    chk("both_mode", 10'(mode), 10'd0);
    frame();
    chk("both_tr", 10'(turn_r), 10'd0);
    chk("both_tl", 10'(turn_l), 10'd0);

    // Autopilot bounce at both edges.
    d_br = 0; d_bl = 0; d_ae = 1; d_sq = 10'd615; cyc(10);
    chk("auto_mode", 10'(mode), 10'd2);
    frame();
    chk("auto_tl", 10'(turn_l), 10'd1);
    chk("auto_tr", 10'(turn_r), 10'd0);
    d_sq = 10'd0; frame();
    chk("auto_tr2", 10'(turn_r), 10'd1);
    chk("auto_tl2", 10'(turn_l), 10'd0);

    // Manual override in AUTO, then back with direction kept.
    d_sq = 10'd300; d_bl = 1; cyc(10);
    chk("ovr_mode", 10'(mode), 10'd1);
    frame();
    chk("ovr_tl", 10'(turn_l), 10'd1);
    d_bl = 0; cyc(10);
    chk("ret_mode", 10'(mode), 10'd2);
    frame();
    chk("ret_dir_tr", 10'(turn_r), 10'd1);

    // Reset mid-frame with turn_r active.
    d_ae = 0; d_br = 1; cyc(10); frame();
    chk("pre_rst_tr", 10'(turn_r), 10'd1);
    d_px = 10'd100; d_py = 10'd100; cyc(1);
    do_reset();
    tick_mark = tick_cnt;
    d_br = 0; cyc(3);
    chk("post_rst_notick", 10'(tick_cnt - tick_mark), 10'd0);
    d_px = 10'd639; d_py = 10'd479; cyc(2);
    chk("post_rst_tick", 10'(tick_cnt - tick_mark), 10'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) d_br = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) d_bl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) d_ae = ~d_ae;
      if ($urandom_range(0, 19) == 0) begin
        d_px = 10'd639; d_py = 10'd479;
      end else begin
        d_px = 10'($urandom_range(0, 639));
        d_py = 10'($urandom_range(0, 479));
      end
      case ($urandom_range(0, 4))
        0:       d_sq = 10'd0;
        1:       d_sq = 10'd615;
        2:       d_sq = 10'd620;
        3:       d_sq = 10'd300;
        default: d_sq = 10'($urandom_range(0, 639));
      endcase
      cyc(1);
      if (i == 900) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
